// File: rtl/fifo_uart_streamer_pkg.sv
// Shared types and constants for fifo_uart_streamer.
// CR/LF states and constants exist only when STREAM_NEWLINE_EN is defined.
package fifo_uart_streamer_pkg;

  localparam int unsigned DEFAULT_WORD_BYTES  = 4;
  localparam int unsigned DEFAULT_ACK_TIMEOUT = 1023;

`ifdef STREAM_NEWLINE_EN
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    StIdle, StRead, StLatch, StSend, StWaitBusy, StWaitDone, StCr, StLf
  } state_e;

  // What the byte currently in flight is, so WAIT_DONE knows where to go next.
  typedef enum logic [1:0] {
    KindPayload, KindCr, KindLf
  } kind_e;
`else
  typedef enum logic [2:0] {
    StIdle, StRead, StLatch, StSend, StWaitBusy, StWaitDone
  } state_e;
`endif

endpackage

// File: rtl/stream_ack_timer.sv
// Loadable up-counter for the transmitter acknowledge window.
// expired is high while the count sits at LIMIT-1, the last cycle of the window.
module stream_ack_timer #(
  parameter int unsigned LIMIT = 1023
) (
  input  logic clk_50,
  input  logic clr,
  input  logic load,
  input  logic inc,
  output logic expired
);

  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] count_q;

  always_ff @(posedge clk_50 or posedge clr) begin
    if (clr) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= '0;
    end else if (inc && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/fifo_uart_streamer.sv
// Drains a byte FIFO into a UART transmitter, one handshaked byte at a time.
// Define STREAM_NEWLINE_EN to append CR/LF after every WORD_BYTES payload bytes.
module fifo_uart_streamer
  import fifo_uart_streamer_pkg::*;
#(
  parameter int unsigned WORD_BYTES  = DEFAULT_WORD_BYTES,
  parameter int unsigned ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic        clk_50,
  input  logic        clr,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_q,
  output logic        fifo_rdreq,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_wr_en,
  output logic [15:0] byte_count,
  output logic        err_timeout
);

  state_e      state_q, state_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [15:0] byte_count_q, byte_count_d;
  logic [7:0]  word_idx_q, word_idx_d;
  logic        err_q, err_d;
  logic        timer_load, timer_inc, timer_expired;
  logic        last_byte;
`ifdef STREAM_NEWLINE_EN
  kind_e       kind_q, kind_d;
`endif

  stream_ack_timer #(
    .LIMIT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk_50  (clk_50),
    .clr     (clr),
    .load    (timer_load),
    .inc     (timer_inc),
    .expired (timer_expired)
  );

  assign last_byte = (word_idx_q == 8'(WORD_BYTES - 1));

  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    byte_count_d = byte_count_q;
    word_idx_d   = word_idx_q;
    err_d        = err_q;
    timer_load   = 1'b0;
    timer_inc    = 1'b0;
`ifdef STREAM_NEWLINE_EN
    kind_d       = kind_q;
`endif
    unique case (state_q)
      StIdle: if (enable && !fifo_empty) state_d = StRead;
      StRead: state_d = StLatch;
      StLatch: begin
        tx_data_d = fifo_q;
`ifdef STREAM_NEWLINE_EN
        kind_d    = KindPayload;
`endif
        state_d   = StSend;
      end
      StSend: begin
        timer_load = 1'b1;
        state_d    = StWaitBusy;
      end
      StWaitBusy: begin
        if (tx_busy) begin
          state_d = StWaitDone;
        end else if (timer_expired) begin
          // Unacknowledged byte is dropped; any pending CR/LF goes with it.
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          timer_inc = 1'b1;
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          state_d = StIdle;
`ifdef STREAM_NEWLINE_EN
          unique case (kind_q)
            KindCr: state_d = StLf;
            KindLf: state_d = StIdle;
            default: begin
              byte_count_d = byte_count_q + 16'd1;
              word_idx_d   = last_byte ? 8'd0 : word_idx_q + 8'd1;
              if (last_byte) state_d = StCr;
            end
          endcase
`else
          byte_count_d = byte_count_q + 16'd1;
          word_idx_d   = last_byte ? 8'd0 : word_idx_q + 8'd1;
`endif
        end
      end
`ifdef STREAM_NEWLINE_EN
      StCr: begin
        tx_data_d = ASCII_CR;
        kind_d    = KindCr;
        state_d   = StSend;
      end
      StLf: begin
        tx_data_d = ASCII_LF;
        kind_d    = KindLf;
        state_d   = StSend;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_50 or posedge clr) begin
    if (clr) begin
      state_q      <= StIdle;
      tx_data_q    <= 8'h00;
      byte_count_q <= 16'h0000;
      word_idx_q   <= 8'h00;
      err_q        <= 1'b0;
`ifdef STREAM_NEWLINE_EN
      kind_q       <= KindPayload;
`endif
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      byte_count_q <= byte_count_d;
      word_idx_q   <= word_idx_d;
      err_q        <= err_d;
`ifdef STREAM_NEWLINE_EN
      kind_q       <= kind_d;
`endif
    end
  end

  assign fifo_rdreq  = (state_q == StRead);
  assign tx_wr_en    = (state_q == StSend);
  assign tx_data     = tx_data_q;
  assign byte_count  = byte_count_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_fifo_uart_streamer.sv
// Randomized bench for fifo_uart_streamer: FIFO and UART models plus a byte-stream reference.
module tb_fifo_uart_streamer;

  localparam int unsigned WB  = 4;
  localparam int unsigned ACK = 40;

  logic        clk_50 = 1'b0;
  logic        clr = 1'b1;
  logic        enable = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_q = 8'h00;
  logic        fifo_rdreq;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_wr_en;
  logic [15:0] byte_count;
  logic        err_timeout;

  always #10 clk_50 = ~clk_50;

  fifo_uart_streamer #(
    .WORD_BYTES  (WB),
    .ACK_TIMEOUT (ACK)
  ) dut (
    .clk_50      (clk_50),
    .clr         (clr),
    .enable      (enable),
    .fifo_empty  (fifo_empty),
    .fifo_q      (fifo_q),
    .fifo_rdreq  (fifo_rdreq),
    .tx_busy     (tx_busy),
    .tx_data     (tx_data),
    .tx_wr_en    (tx_wr_en),
    .byte_count  (byte_count),
    .err_timeout (err_timeout)
  );

  int checks = 0;
  int errors = 0;

  // FIFO model: writer is the stimulus, reader is the DUT's rdreq.
  logic [7:0] fifo_mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rdreq_total = 0;
  int viol_rd = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk_50) begin
    if (fifo_rdreq) begin
      rdreq_total <= rdreq_total + 1;
      if (fifo_empty) viol_rd <= viol_rd + 1;
      else begin
        fifo_q <= fifo_mem[rd_ptr % 256];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  // UART model: logs every strobed byte, acknowledges with busy after a delay.
  bit         ack_en = 1'b1;
  bit         rand_timing = 1'b0;
  int         ack_wait = 0;
  int         busy_left = 0;
  int         pend_len = 0;
  int         d_tmp;
  int         len_tmp;
  int         viol_tx = 0;
  logic [7:0] uart_log[$];

  always @(posedge clk_50) begin
    if (tx_wr_en) begin
      uart_log.push_back(tx_data);
      if (tx_busy) viol_tx <= viol_tx + 1;
      if (ack_en) begin
        d_tmp   = rand_timing ? int'($urandom_range(0, 3)) : 0;
        len_tmp = rand_timing ? int'($urandom_range(2, 20)) : 20;
        if (d_tmp == 0) begin
          tx_busy   <= 1'b1;
          busy_left <= len_tmp;
        end else begin
          ack_wait <= d_tmp;
          pend_len <= len_tmp;
        end
      end
    end else if (ack_wait > 0) begin
      if (ack_wait == 1) begin
        tx_busy   <= 1'b1;
        busy_left <= pend_len;
      end
      ack_wait <= ack_wait - 1;
    end else if (tx_busy) begin
      if (busy_left <= 1) tx_busy <= 1'b0;
      busy_left <= busy_left - 1;
    end
  end

  // Reference: what the UART must see and what byte_count must read.
  logic [7:0]  exp_log[$];
  logic [15:0] model_count = 16'h0000;
  int          model_idx = 0;

  task automatic model_send(input logic [7:0] b, input bit acked);
    exp_log.push_back(b);
    if (acked) begin
      model_count = model_count + 16'd1;
      model_idx++;
      if (model_idx == int'(WB)) begin
        model_idx = 0;
`ifdef STREAM_NEWLINE_EN
        exp_log.push_back(8'h0D);
        exp_log.push_back(8'h0A);
`endif
      end
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_mem[wr_ptr % 256] = b;
    wr_ptr++;
  endtask

  function automatic int first_diff();
    int n = (uart_log.size() < exp_log.size()) ? uart_log.size() : exp_log.size();
    for (int i = 0; i < n; i++) if (uart_log[i] !== exp_log[i]) return i;
    if (uart_log.size() != exp_log.size()) return n;
    return -1;
  endfunction

  task automatic do_clr();
    @(negedge clk_50);
    clr = 1'b1;
    @(negedge clk_50);
    clr = 1'b0;
    model_count = 16'h0000;
    model_idx   = 0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((uart_log.size() != exp_log.size() || tx_busy || ack_wait != 0) && n < 4000) begin
      @(negedge clk_50);
      n++;
    end
    if (n >= 4000) begin
      checks++;
      errors++;
      $display("FAIL %s_wait: transfer still open after %0d cycles, required done", name, n);
    end
    repeat (4) @(negedge clk_50);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_50);
    checks++; if (fifo_rdreq !== 1'b0) begin errors++;
      $display("FAIL reset_rdreq: got %b, required 0", fifo_rdreq); end
    checks++; if (tx_wr_en !== 1'b0) begin errors++;
      $display("FAIL reset_wr_en: got %b, required 0", tx_wr_en); end
    checks++; if (tx_data !== 8'h00) begin errors++;
      $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
    checks++; if (byte_count !== 16'h0000) begin errors++;
      $display("FAIL reset_count: got %h, required 0000", byte_count); end
    checks++; if (err_timeout !== 1'b0) begin errors++;
      $display("FAIL reset_err: got %b, required 0", err_timeout); end
    clr = 1'b0;
    @(negedge clk_50);
    checks++; if ({fifo_rdreq, tx_wr_en} !== 2'b00) begin errors++;
      $display("FAIL release_strobe: got %b, required 00", {fifo_rdreq, tx_wr_en}); end
  endtask

  task automatic test_single();
    int base_rd = rdreq_total;
    int diff;
    rand_timing = 1'b0;
    push_byte(8'hA5);
    model_send(8'hA5, 1'b1);
    enable = 1'b1;
    wait_done("single");
    diff = first_diff();
    checks++; if (diff !== -1) begin errors++;
      $display("FAIL single_stream: diverges at byte %0d, saw %0d bytes, required %0d",
               diff, uart_log.size(), exp_log.size()); end
    checks++; if (byte_count !== model_count) begin errors++;
      $display("FAIL single_count: got %h, required %h", byte_count, model_count); end
    repeat (30) @(negedge clk_50);
    checks++; if (rdreq_total - base_rd !== 1) begin errors++;
      $display("FAIL single_rdreq: got %0d reads, required 1", rdreq_total - base_rd); end
  endtask

  task automatic test_word();
    int diff;
    do_clr();
    for (int i = 1; i <= 4; i++) begin
      push_byte(8'(i * 17));
      model_send(8'(i * 17), 1'b1);
    end
    wait_done("word");
    diff = first_diff();
    checks++; if (diff !== -1) begin errors++;
      $display("FAIL word_stream: diverges at byte %0d, saw %0d bytes, required %0d",
               diff, uart_log.size(), exp_log.size()); end
    checks++; if (byte_count !== 16'd4) begin errors++;
      $display("FAIL word_count: got %0d, required 4", byte_count); end
  endtask

  task automatic test_random();
    int base_rd = rdreq_total;
    int n = int'($urandom_range(8, 14));
    int diff;
    logic [7:0] b;
    rand_timing = 1'b1;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      push_byte(b);
      model_send(b, 1'b1);
    end
    wait_done("random");
    diff = first_diff();
    checks++; if (diff !== -1) begin errors++;
      $display("FAIL random_stream: diverges at byte %0d, saw %0d bytes, required %0d",
               diff, uart_log.size(), exp_log.size()); end
    checks++; if (byte_count !== model_count) begin errors++;
      $display("FAIL random_count: got %h, required %h", byte_count, model_count); end
    checks++; if (rdreq_total - base_rd !== n) begin errors++;
      $display("FAIL random_rdreq: got %0d reads, required %0d", rdreq_total - base_rd, n); end
    checks++; if (viol_rd !== 0) begin errors++;
      $display("FAIL rdreq_when_empty: got %0d, required 0", viol_rd); end
    checks++; if (viol_tx !== 0) begin errors++;
      $display("FAIL strobe_while_busy: got %0d, required 0", viol_tx); end
  endtask

  task automatic test_timeout();
    int n = 0;
    int diff;
    logic [7:0] b = 8'($urandom);
    ack_en = 1'b0;
    push_byte(b);
    model_send(b, 1'b0);
    do begin
      @(negedge clk_50);
      n++;
    end while (tx_wr_en !== 1'b1 && n < 200);
    checks++; if (n >= 200) begin errors++;
      $display("FAIL timeout_strobe: no tx_wr_en in %0d cycles, required one", n); end
    repeat (ACK) @(negedge clk_50);
    checks++; if (err_timeout !== 1'b0) begin errors++;
      $display("FAIL timeout_early: got %b one cycle before limit, required 0", err_timeout); end
    @(negedge clk_50);
    checks++; if (err_timeout !== 1'b1) begin errors++;
      $display("FAIL timeout_flag: got %b at limit, required 1", err_timeout); end
    checks++; if (byte_count !== model_count) begin errors++;
      $display("FAIL timeout_count: got %h, required %h", byte_count, model_count); end
    ack_en = 1'b1;
    b = 8'($urandom);
    push_byte(b);
    model_send(b, 1'b1);
    wait_done("after_timeout");
    diff = first_diff();
    checks++; if (diff !== -1) begin errors++;
      $display("FAIL timeout_stream: diverges at byte %0d, saw %0d bytes, required %0d",
               diff, uart_log.size(), exp_log.size()); end
    checks++; if (byte_count !== model_count) begin errors++;
      $display("FAIL after_timeout_count: got %h, required %h", byte_count, model_count); end
    checks++; if (err_timeout !== 1'b1) begin errors++;
      $display("FAIL err_sticky: got %b, required 1", err_timeout); end
    do_clr();
    checks++; if (err_timeout !== 1'b0) begin errors++;
      $display("FAIL err_clear: got %b after clr, required 0", err_timeout); end
  endtask

  task automatic test_enable_drop();
    int base_log;
    int base_rd;
    int n = 0;
    int diff;
    logic [7:0] b [4];
    do_clr();
    rand_timing = 1'b1;
    base_log = uart_log.size();
    base_rd  = rdreq_total;
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom);
      push_byte(b[i]);
    end
    model_send(b[0], 1'b1);
    model_send(b[1], 1'b1);
    while (!(uart_log.size() == base_log + 2 && tx_busy) && n < 500) begin
      @(negedge clk_50);
      n++;
    end
    checks++; if (n >= 500) begin errors++;
      $display("FAIL drop_reach: second byte not busy after %0d cycles, required busy", n); end
    @(negedge clk_50);
    enable = 1'b0;
    wait_done("drop");
    repeat (40) @(negedge clk_50);
    diff = first_diff();
    checks++; if (diff !== -1) begin errors++;
      $display("FAIL drop_stream: diverges at byte %0d, saw %0d bytes, required %0d",
               diff, uart_log.size(), exp_log.size()); end
    checks++; if (byte_count !== 16'd2) begin errors++;
      $display("FAIL drop_count: got %0d, required 2", byte_count); end
    checks++; if (rdreq_total - base_rd !== 2) begin errors++;
      $display("FAIL drop_rdreq: got %0d reads, required 2", rdreq_total - base_rd); end
    enable = 1'b1;
    model_send(b[2], 1'b1);
    model_send(b[3], 1'b1);
    wait_done("resume");
    diff = first_diff();
    checks++; if (diff !== -1) begin errors++;
      $display("FAIL resume_stream: diverges at byte %0d, saw %0d bytes, required %0d",
               diff, uart_log.size(), exp_log.size()); end
    checks++; if (byte_count !== 16'd4) begin errors++;
      $display("FAIL resume_count: got %0d, required 4", byte_count); end
  endtask

  task automatic test_clr_mid();
    int n = 0;
    int base_log;
    int diff;
    rand_timing = 1'b0;
    push_byte(8'hC3);
    model_send(8'hC3, 1'b0);
    while (tx_busy !== 1'b1 && n < 200) begin
      @(negedge clk_50);
      n++;
    end
    checks++; if (n >= 200) begin errors++;
      $display("FAIL clr_reach: tx_busy never rose in %0d cycles, required 1", n); end
    @(negedge clk_50);
    clr = 1'b1;
    #1;
    checks++;
    if ({fifo_rdreq, tx_wr_en, tx_data, byte_count, err_timeout} !== 27'd0) begin
      errors++;
      $display("FAIL clr_async: rdreq=%b wr_en=%b data=%h count=%h err=%b, required all 0",
               fifo_rdreq, tx_wr_en, tx_data, byte_count, err_timeout);
    end
    @(negedge clk_50);
    clr = 1'b0;
    model_count = 16'h0000;
    model_idx   = 0;
    base_log = uart_log.size();
    repeat (30) @(negedge clk_50);
    checks++; if (uart_log.size() !== base_log) begin errors++;
      $display("FAIL clr_quiet: got %0d strobes with FIFO empty, required 0",
               uart_log.size() - base_log); end
    push_byte(8'h5A);
    model_send(8'h5A, 1'b1);
    wait_done("clr_after");
    diff = first_diff();
    checks++; if (diff !== -1) begin errors++;
      $display("FAIL clr_stream: diverges at byte %0d, saw %0d bytes, required %0d",
               diff, uart_log.size(), exp_log.size()); end
    checks++; if (byte_count !== 16'd1) begin errors++;
      $display("FAIL clr_count: got %0d, required 1", byte_count); end
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    rand_timing = 1'b1;
    @(negedge clk_50);
    force dut.byte_count_q = 16'hFFFF;
    @(negedge clk_50);
    release dut.byte_count_q;
    model_count = 16'hFFFF;
    b = 8'($urandom);
    push_byte(b);
    model_send(b, 1'b1);
    wait_done("wrap");
    checks++; if (byte_count !== 16'h0000) begin errors++;
      $display("FAIL wrap_count: got %h, required 0000", byte_count); end
    b = 8'($urandom);
    push_byte(b);
    model_send(b, 1'b1);
    wait_done("post_wrap");
    checks++; if (byte_count !== model_count) begin errors++;
      $display("FAIL post_wrap_count: got %h, required %h", byte_count, model_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_word();
    test_random();
    test_timeout();
    test_enable_drop();
    test_clr_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
